// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain path: sequencer state encoding and
// the total gain range of a VGA cascade.
package agc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } agc_state_e;

    // Highest legal gain index: every stage but the last saturates at
    // stage_max, and the last stage adds up to last_max on top of them.
    function automatic int gain_max(input int num_stages,
                                    input int stage_max,
                                    input int last_max);
        return (num_stages - 1) * stage_max + last_max;
    endfunction

endpackage

// File: rtl/gain_to_vga_map.sv
// Combinational mapping from a gain index to the flattened VGA code bus.
// Stage 0 fills first; each stage only starts once all lower stages are full.
module gain_to_vga_map #(
    parameter int NUM_STAGES = 3,
    parameter int CODE_W     = 5,
    parameter int STAGE_MAX  = 10,
    parameter int LAST_MAX   = 18,
    parameter int GAIN_W     = 6
) (
    input  logic [GAIN_W-1:0]            gain_i,
    output logic [NUM_STAGES*CODE_W-1:0] codes_o
);

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            localparam int BASE   = gi * STAGE_MAX;
            localparam int CODE_M = (gi == NUM_STAGES - 1) ? LAST_MAX : STAGE_MAX;

            int                diff;
            int                clip;
            logic [CODE_W-1:0] code;

            // Portion of the gain above this stage's base, clipped to its range
            always_comb begin
                diff = int'(gain_i) - BASE;
                clip = diff;
                if (diff < 0) begin
                    clip = 0;
                end else if (diff > CODE_M) begin
                    clip = CODE_M;
                end
                code = CODE_W'(clip);
            end

            assign codes_o[gi*CODE_W +: CODE_W] = code;
        end
    endgenerate

endmodule

// File: rtl/vga_gain_sequencer.sv
// Moves the VGA cascade toward a requested gain index, either in one jump
// or one code at a time, waiting a settle interval after every applied step.
module vga_gain_sequencer
    import agc_pkg::*;
#(
    parameter int NUM_STAGES    = 3,
    parameter int CODE_W        = 5,
    parameter int STAGE_MAX     = 10,
    parameter int LAST_MAX      = 18,
    parameter int GAIN_W        = 6,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [GAIN_W-1:0]            gain_req,
    input  logic                         gain_req_valid,
    output logic                         gain_req_ready,
    input  logic                         ramp_mode,
    input  logic                         hold,
    output logic [NUM_STAGES*CODE_W-1:0] vga_control,
    output logic [GAIN_W-1:0]            gain_cur,
    output logic                         busy,
    output logic                         done,
    output logic                         clamped
);

    localparam int                GAIN_MAX    = gain_max(NUM_STAGES, STAGE_MAX, LAST_MAX);
    localparam logic [GAIN_W-1:0] GAIN_MAX_G  = GAIN_W'(GAIN_MAX);
    localparam int                CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(1);
    localparam logic [GAIN_W-1:0] GAIN_ONE    = GAIN_W'(1);

    agc_state_e                    state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [GAIN_W-1:0]             gain_q;
    logic [GAIN_W-1:0]             gain_d;
    logic [GAIN_W-1:0]             target_q;
    logic                          ramp_q;
    logic                          done_q;
    logic                          clamped_q;
    logic [NUM_STAGES*CODE_W-1:0]  vga_q;
    logic [NUM_STAGES*CODE_W-1:0]  vga_d;

    logic                          req_over;
    logic [GAIN_W-1:0]             req_target;

    assign req_over   = (gain_req > GAIN_MAX_G);
    assign req_target = req_over ? GAIN_MAX_G : gain_req;

    // Next applied gain: only a STEP cycle without hold moves it
    always_comb begin
        gain_d = gain_q;
        if (state_q == STEP && !hold) begin
            if (!ramp_q) begin
                gain_d = target_q;
            end else if (target_q > gain_q) begin
                gain_d = gain_q + GAIN_ONE;
            end else begin
                gain_d = gain_q - GAIN_ONE;
            end
        end
    end

    // Codes are derived from the next gain so gain_cur and vga_control
    // change on the same edge with no intermediate value visible.
    gain_to_vga_map #(
        .NUM_STAGES (NUM_STAGES),
        .CODE_W     (CODE_W),
        .STAGE_MAX  (STAGE_MAX),
        .LAST_MAX   (LAST_MAX),
        .GAIN_W     (GAIN_W)
    ) u_map (
        .gain_i  (gain_d),
        .codes_o (vga_d)
    );

    // Sequencer FSM with registered gain, codes and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gain_q    <= '0;
            vga_q     <= '0;
            target_q  <= '0;
            ramp_q    <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            gain_q <= gain_d;
            vga_q  <= vga_d;
            case (state_q)
                IDLE: begin
                    if (gain_req_valid) begin
                        target_q  <= req_target;
                        ramp_q    <= ramp_mode;
                        clamped_q <= req_over;
                        if (req_target == gain_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= STEP;
                        end
                    end
                end
                STEP: begin
                    if (!hold) begin
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Leaving on the edge where the count would reach zero
                    // gives exactly SETTLE_CYCLES cycles in this state.
                    if (!hold) begin
                        if (cnt_q <= CNT_LAST) begin
                            cnt_q <= '0;
                            if (gain_q != target_q) begin
                                state_q <= STEP;
                            end else begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_LAST;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gain_req_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign clamped        = clamped_q;
    assign gain_cur       = gain_q;
    assign vga_control    = vga_q;

endmodule

// File: tb/tb_vga_gain_sequencer.sv
// Randomized self-checking bench for vga_gain_sequencer against a timeline
// model derived from the step/settle schedule.
module tb_vga_gain_sequencer;

    localparam int NS   = 3;
    localparam int CW   = 5;
    localparam int SM   = 10;
    localparam int LM   = 18;
    localparam int GW   = 6;
    localparam int SC   = 4;
    localparam int GMAX = (NS - 1) * SM + LM;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [GW-1:0]     gain_req = '0;
    logic              gain_req_valid = 1'b0;
    logic              gain_req_ready;
    logic              ramp_mode = 1'b0;
    logic              hold = 1'b0;
    logic [NS*CW-1:0]  vga_control;
    logic [GW-1:0]     gain_cur;
    logic              busy;
    logic              done;
    logic              clamped;

    int n_checks = 0;
    int n_fails  = 0;
    int model_gain  = 0;
    int model_clamp = 0;

    vga_gain_sequencer #(
        .NUM_STAGES    (NS),
        .CODE_W        (CW),
        .STAGE_MAX     (SM),
        .LAST_MAX      (LM),
        .GAIN_W        (GW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .gain_req       (gain_req),
        .gain_req_valid (gain_req_valid),
        .gain_req_ready (gain_req_ready),
        .ramp_mode      (ramp_mode),
        .hold           (hold),
        .vga_control    (vga_control),
        .gain_cur       (gain_cur),
        .busy           (busy),
        .done           (done),
        .clamped        (clamped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stage codes for a gain index: each stage takes what is left above
    // the stages below it, up to its own maximum.
    function automatic int exp_vga(input int g);
        int r;
        int c;
        int mx;
        r = 0;
        for (int i = 0; i < NS; i++) begin
            mx = (i == NS - 1) ? LM : SM;
            c  = g - i * SM;
            if (c < 0) c = 0;
            if (c > mx) c = mx;
            r = r | (c << (i * CW));
        end
        return r;
    endfunction

    task automatic do_reset();
        gain_req_valid = 1'b0;
        hold = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        model_gain  = 0;
        model_clamp = 0;
        chk("rst_gain", int'(gain_cur), 0);
        chk("rst_vga", int'(vga_control), 0);
        chk("rst_ready", int'(gain_req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_clamped", int'(clamped), 0);
    endtask

    // Issue one request and follow it to completion, comparing every cycle
    // with the schedule: step n lands after 1+(n-1)*(SC+1) unheld edges.
    task automatic run_req(input int gval, input bit ramp, input int hold_at,
                           input int hold_len, input int hold_pct, input int rst_at);
        int  tgt, n, start, dir, total, teff, edges, holds, fixed_holds;
        int  steps, expg, changes, prev_vga, cyc;
        bit  hold_now;
        chk("ready_at_req", int'(gain_req_ready), 1);
        gain_req       = GW'(gval);
        ramp_mode      = ramp;
        gain_req_valid = 1'b1;
        @(posedge clk); #1;
        gain_req_valid = 1'b0;

        tgt   = (gval > GMAX) ? GMAX : gval;
        start = model_gain;
        model_clamp = (gval > GMAX) ? 1 : 0;
        dir   = (tgt >= start) ? 1 : -1;
        if (ramp) n = (tgt - start) * dir;
        else      n = (tgt == start) ? 0 : 1;
        total = n * (SC + 1);
        teff = 0; edges = 0; holds = 0; fixed_holds = 0;
        changes = 0; prev_vga = exp_vga(start); cyc = 0;

        forever begin
            steps = (teff < 1) ? 0 : (((teff - 1) / (SC + 1) + 1 > n) ? n : (teff - 1) / (SC + 1) + 1);
            if (ramp) expg = start + dir * steps;
            else      expg = (steps > 0) ? tgt : start;
            chk("gain_cur", int'(gain_cur), expg);
            chk("vga_control", int'(vga_control), exp_vga(expg));
            chk("busy", int'(busy), (teff < total) ? 1 : 0);
            chk("ready", int'(gain_req_ready), (teff < total) ? 0 : 1);
            chk("done", int'(done), (teff == total) ? 1 : 0);
            chk("clamped", int'(clamped), model_clamp);
            if (int'(vga_control) != prev_vga) changes++;
            prev_vga = int'(vga_control);
            $display("req %0d ramp %0d edge %0d gain %0d busy %0d done %0d hold %0d",
                     gval, ramp, edges, gain_cur, busy, done, hold);

            if (rst_at >= 0 && expg == rst_at) begin
                do_reset();
                return;
            end
            if (teff == total) begin
                gain_req_valid = 1'b0;
                hold = 1'b0;
                break;
            end
            if (cyc > 3000) begin
                chk("timeout", 0, 1);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
                $finish;
            end

            hold_now = 1'b0;
            if (hold_at >= 0 && teff >= hold_at && fixed_holds < hold_len) begin
                hold_now = 1'b1;
                fixed_holds++;
            end else if ($urandom_range(99) < hold_pct) begin
                hold_now = 1'b1;
            end
            hold = hold_now;
            // Requests offered while busy must be ignored
            gain_req_valid = $urandom_range(1);
            gain_req       = GW'($urandom);
            ramp_mode      = $urandom_range(1);
            @(posedge clk); #1;
            edges++;
            cyc++;
            if (hold_now) holds++;
            else          teff++;
        end

        chk("done_latency", edges, total + holds);
        chk("code_changes", changes, n);
        model_gain = tgt;
        @(posedge clk); #1;
        chk("done_pulse", int'(done), 0);
        chk("gain_final", int'(gain_cur), tgt);
    endtask

    initial begin
        do_reset();

        // Full ramp 0 -> 38
        run_req(38, 1'b1, -1, 0, 0, -1);
        chk("codes_38", int'(vga_control), 10 | (10 << CW) | (18 << (2 * CW)));

        // Ramp down 38 -> 35 with three hold cycles inside the first settle
        run_req(35, 1'b1, 3, 3, 0, -1);
        chk("codes_35", int'(vga_control), 10 | (10 << CW) | (15 << (2 * CW)));

        // No-op request
        run_req(35, 1'b1, -1, 0, 0, -1);

        // Reset while ramping down through gain 12
        run_req(0, 1'b1, -1, 0, 0, 12);

        // Immediate jump 0 -> 15
        run_req(15, 1'b0, -1, 0, 0, -1);
        chk("codes_15", int'(vga_control), 10 | (5 << CW));

        // Out-of-range request clamps, then an in-range one clears the flag
        run_req(63, 1'b0, -1, 0, 0, -1);
        chk("clamped_63", int'(clamped), 1);
        run_req(20, 1'b1, -1, 0, 20, -1);
        chk("clamped_20", int'(clamped), 0);
        chk("codes_20", int'(vga_control), 10 | (10 << CW));

        // Random requests with random holds and busy-time noise
        for (int i = 0; i < 12; i++) begin
            run_req($urandom_range(63), $urandom_range(1), -1, 0, 15, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_gain_sequencer.md
# vga_gain_sequencer

Parametrised, registered successor to the combinational gain-to-VGA mapping in the AGC path. Accepts a target gain index over a valid/ready handshake, clamps it to the legal range, and moves the VGA chain toward it. Moves are either immediate or one code step at a time, with a programmable settle interval after every step so the analog VGAs never see large code jumps. Sits between the AGC loop controller and the VGA control pins; the VGA codes are fully registered.

## Interface
- NUM_STAGES, 3: number of cascaded VGA stages, ≥2; stage 0 fills first.
- CODE_W, 5: width of each stage control code.
- STAGE_MAX, 10: maximum code of stages 0..NUM_STAGES-2.
- LAST_MAX, 18: maximum code of stage NUM_STAGES-1.
- GAIN_W, 6: width of gain index; must hold GAIN_MAX = (NUM_STAGES-1)*STAGE_MAX + LAST_MAX (38 by default).
- SETTLE_CYCLES, 4: idle cycles after each applied step, ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- gain_req  in  GAIN_W  target gain index.
- gain_req_valid  in  1  request valid.
- gain_req_ready  out  1  high only in IDLE.
- ramp_mode  in  1  sampled on accept; 1 = step ±1 per interval, 0 = jump in one step.
- hold  in  1  freezes the step/settle progress while high.
- vga_control  out  NUM_STAGES*CODE_W  stage i code at bits [i*CODE_W +: CODE_W].
- gain_cur  out  GAIN_W  currently applied gain index.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when the target is reached and settled.
- clamped  out  1  set on accepting a request with gain_req > GAIN_MAX; cleared on accepting an in-range request.

## Operation
- Mapping of g = gain_cur:
  - Stage i < NUM_STAGES-1: code = min(max(g − i*STAGE_MAX, 0), STAGE_MAX).
  - Last stage: code = min(max(g − (NUM_STAGES-1)*STAGE_MAX, 0), LAST_MAX).
  - Codes are zero-extended to CODE_W.
- Reset: gain_cur=0, vga_control=0, clamped=0, done=0, busy=0, gain_req_ready=1, state IDLE. Reset mid-ramp behaves identically and discards the target.
- FSM states:
  - IDLE: accept on valid&&ready; target = min(gain_req, GAIN_MAX); latch ramp_mode. If target == gain_cur, pulse done next cycle and stay IDLE. Otherwise go to STEP.
  - STEP: apply one step in one cycle. Ramp mode moves gain_cur ±1 toward target. Immediate mode sets gain_cur = target. Then go to SETTLE with the counter loaded to SETTLE_CYCLES.
  - SETTLE: decrement the counter. At 0, go to STEP if gain_cur ≠ target; else go to IDLE with done=1 for that cycle.
- hold=1 freezes state, the counter, and gain_cur. Outputs hold their values. A transition already registered is not affected.
- gain_req and ramp_mode are ignored while busy; there is no queueing or retargeting mid-move.

## Timing
- vga_control and gain_cur update on the same edge, registered from the next gain value. They never show intermediate codes.
- With accept at edge k, N steps (N = |target − gain_cur| in ramp mode, 1 in immediate mode), and no hold:
  - Step n lands at edge k+1+(n−1)*(SETTLE_CYCLES+1).
  - done and gain_req_ready are high in the cycle after edge k+N*(SETTLE_CYCLES+1).
- No-op request: done is high in the cycle after edge k; ready stays high.
- Each asserted hold cycle extends the total by exactly one cycle.

## Structure
- Shared package agc_pkg holds:
  - the state enum (IDLE, STEP, SETTLE);
  - a gain_max(NUM_STAGES, STAGE_MAX, LAST_MAX) constant function.
- Sub-module gain_to_vga_map: a purely combinational, parametrised mapper from gain index to the flattened code bus. The sequencer instantiates it on the next gain value and registers its output.

## Test plan
- Reset, then ramp request 38 with SETTLE_CYCLES=4 → gain_cur reaches 38. Final vga_control stage0=10, stage1=10, stage2=18. done pulse in the cycle after edge k+190; exactly 38 code changes.
- Immediate request 15 from 0 → a single update at edge k+1 to stage0=10, stage1=5, stage2=0; done after edge k+5.
- Request 63 → clamped=1, target 38. A following request 20 → clamped=0 and final codes 10/10/0.
- Ramp 38→35 with hold high for 3 cycles mid-settle → codes step down 18→17→16→15 in stage2 only; done is delayed by exactly 3 cycles.
- Request equal to gain_cur → no vga_control change; done in the next cycle; busy stays 0.
- rst asserted mid-ramp at gain 12 → the next cycle shows gain_cur=0, vga_control=0, ready=1. A request presented while busy is never accepted.
